// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: shared types and constant tables for the 12-bit fetch-stage
// program-counter sequencer.
//   state_t    : sequencer states (IDLE, RUN, DONE)
//   ENTRY      : program entry addresses selected by prog_sel
//   JUMP_TABLE : absolute jump targets selected by target_idx
// Table entries are 16 bits wide; consumers resize them to the PC width.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] ENTRY [0:3] = '{16'd0, 16'd100, 16'd200, 16'd300};

    // Entries 4..15 come from the current program image. Entry 14 is wider
    // than the PC on purpose; it is truncated to the PC width on use.
    localparam logic [15:0] JUMP_TABLE [0:15] = '{
        16'd1,    16'd18,   16'd31,   16'd54,
        16'd67,   16'd80,   16'd96,   16'd112,
        16'd128,  16'd150,  16'd200,  16'd256,
        16'd512,  16'd1024, 16'h1ABC, 16'd4093
    };

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/fetch bundle between the top level, decode, ALU
// and the PC sequencer.
//   start, prog_sel           : launch request and program select
//   stall                     : freeze the sequencer this cycle
//   branch_en, branch_taken,
//   target_idx, halt          : decoded instruction controls
//   pc, running, done,
//   cycle_cnt                 : sequencer outputs
// master drives the controls; slave is the sequencer.
interface pc_sequencer_if #(
    parameter int D  = 12,
    parameter int CW = 16
);

    logic          start;
    logic [1:0]    prog_sel;
    logic          stall;
    logic          branch_en;
    logic          branch_taken;
    logic [3:0]    target_idx;
    logic          halt;
    logic [D-1:0]  pc;
    logic          running;
    logic          done;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output start, prog_sel, stall, branch_en, branch_taken, target_idx, halt,
        input  pc, running, done, cycle_cnt
    );

    modport slave (
        input  start, prog_sel, stall, branch_en, branch_taken, target_idx, halt,
        output pc, running, done, cycle_cnt
    );

endinterface

// File: rtl/pc_sequencer_jump_lut.sv
// jump_lut: combinational jump-target lookup.
//   target_idx in 4 : jump-table index
//   target     out D: JUMP_TABLE[target_idx], zero-extended or truncated to D
module jump_lut
    import pc_pkg::*;
#(
    parameter int D = 12
) (
    input  logic [3:0]   target_idx,
    output logic [D-1:0] target
);

    // Table read resized to the PC width.
    always_comb begin
        target = D'(JUMP_TABLE[target_idx]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, launches a program on start, advances the
// PC by increment or table jump, stops on halt and counts run cycles.
//   clk      in 1 : rising-edge clock
//   reset_n  in 1 : synchronous active-low reset
//   bus      slave: start/prog_sel/stall/branch_en/branch_taken/target_idx/
//                   halt in; pc/running/done/cycle_cnt out (all registered)
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_sequencer_if.slave bus
);

    state_t        state_r;
    state_t        state_next_s;
    logic [D-1:0]  pc_r;
    logic [D-1:0]  pc_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          running_r;
    logic          done_r;
    logic [D-1:0]  jump_target_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    jump_lut #(.D(D)) u_jump_lut (
        .target_idx (bus.target_idx),
        .target     (jump_target_s)
    );

    // Next state, next PC and next count; halt beats a taken jump beats increment.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE, DONE: begin
                // stall has no effect outside RUN
                if (bus.start) begin
                    state_next_s = RUN;
                    pc_next_s    = D'(ENTRY[bus.prog_sel]);
                    cnt_next_s   = {CW{1'b0}};
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    state_next_s = RUN;
                end else begin
                    cnt_next_s = sat_inc(cnt_r);
                    if (bus.halt) begin
                        state_next_s = DONE;
                    end else if (bus.branch_en && bus.branch_taken) begin
                        pc_next_s = jump_target_s;
                    end else begin
                        pc_next_s = pc_r + {{(D-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_next_s = IDLE;
                pc_next_s    = {D{1'b0}};
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, PC, counter and status flags; flags follow the next state so they are registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            pc_r      <= {D{1'b0}};
            cnt_r     <= {CW{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            cnt_r     <= cnt_next_s;
            running_r <= (state_next_s == RUN);
            done_r    <= (state_next_s == DONE);
        end
    end

    assign bus.pc        = pc_r;
    assign bus.running   = running_r;
    assign bus.done      = done_r;
    assign bus.cycle_cnt = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. Each cycle a
// reference model predicts the registered outputs, the prediction is queued,
// and after the clock edge it is popped and compared with the DUT. Directed
// checks against fixed values cover the listed scenarios.
module tb_pc_sequencer;

    typedef struct packed {
        logic [11:0] pc;
        logic        running;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb [$];

    // Independent copies of the program tables.
    logic [15:0] entry_tb [0:3]  = '{16'd0, 16'd100, 16'd200, 16'd300};
    logic [15:0] jump_tb  [0:15] = '{16'd1, 16'd18, 16'd31, 16'd54, 16'd67, 16'd80, 16'd96, 16'd112,
                                     16'd128, 16'd150, 16'd200, 16'd256, 16'd512, 16'd1024, 16'h1ABC, 16'd4093};

    // Reference model state: 0 idle, 1 run, 2 done.
    int          m_state;
    logic [11:0] m_pc;
    logic [15:0] m_cnt;

    pc_sequencer_if #(.D(12), .CW(16)) bus ();

    pc_sequencer #(.D(12), .CW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start        = 1'b0;
        bus.prog_sel     = 2'd0;
        bus.stall        = 1'b0;
        bus.branch_en    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.target_idx   = 4'd0;
        bus.halt         = 1'b0;
    endtask

    // Predict the next outputs, queue them, clock once and compare.
    task automatic step();
        exp_t        e;
        exp_t        got;
        logic [15:0] t;
        if (!reset_n) begin
            m_state = 0;
            m_pc    = 12'd0;
            m_cnt   = 16'd0;
        end else if (m_state == 1) begin
            if (!bus.stall) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (bus.halt) begin
                    m_state = 2;
                end else if (bus.branch_en && bus.branch_taken) begin
                    t    = jump_tb[bus.target_idx];
                    m_pc = t[11:0];
                end else begin
                    m_pc = m_pc + 12'd1;
                end
            end
        end else if (bus.start) begin
            t       = entry_tb[bus.prog_sel];
            m_pc    = t[11:0];
            m_cnt   = 16'd0;
            m_state = 1;
        end
        e.pc      = m_pc;
        e.running = (m_state == 1);
        e.done    = (m_state == 2);
        e.cnt     = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check("pc", 32'(bus.pc), 32'(got.pc));
            check("running", 32'(bus.running), 32'(got.running));
            check("done", 32'(bus.done), 32'(got.done));
            check("cycle_cnt", 32'(bus.cycle_cnt), 32'(got.cnt));
            check("run_done_excl", 32'(bus.running & bus.done), 32'd0);
        end
    endtask

    task automatic do_start(input logic [1:0] ps);
        idle_inputs();
        bus.start    = 1'b1;
        bus.prog_sel = ps;
        step();
        idle_inputs();
    endtask

    task automatic do_jump(input logic [3:0] idx, input logic taken);
        idle_inputs();
        bus.branch_en    = 1'b1;
        bus.branch_taken = taken;
        bus.target_idx   = idx;
        step();
        idle_inputs();
    endtask

    task automatic do_inc(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [15:0] saved_cnt;
        checks  = 0;
        errors  = 0;
        m_state = 0;
        m_pc    = 12'd0;
        m_cnt   = 16'd0;
        idle_inputs();
        reset_n = 1'b0;
        #2;
        step();
        step();
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;

        // reset mid-RUN at pc 57, with start asserted in the same cycle
        do_start(2'd0);
        do_jump(4'd3, 1'b1);
        do_inc(3);
        check("pc_57", 32'(bus.pc), 32'd57);
        reset_n   = 1'b0;
        bus.start = 1'b1;
        step();
        reset_n = 1'b1;
        idle_inputs();
        check("midrun_rst_pc", 32'(bus.pc), 32'd0);
        check("midrun_rst_running", 32'(bus.running), 32'd0);
        check("midrun_rst_done", 32'(bus.done), 32'd0);
        check("midrun_rst_cnt", 32'(bus.cycle_cnt), 32'd0);

        // program 1, five free-running cycles
        do_start(2'd1);
        check("start1_pc", 32'(bus.pc), 32'd100);
        check("start1_running", 32'(bus.running), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            do_inc(1);
            check("seq_pc", 32'(bus.pc), 32'(100 + i));
        end
        check("seq_cnt", 32'(bus.cycle_cnt), 32'd5);

        // taken and not-taken jumps
        do_jump(4'd2, 1'b1);
        check("jump_idx2", 32'(bus.pc), 32'd31);
        do_inc(9);
        check("pc_40", 32'(bus.pc), 32'd40);
        do_jump(4'd3, 1'b0);
        check("not_taken", 32'(bus.pc), 32'd41);

        // start during RUN is ignored
        do_start(2'd3);
        check("start_in_run_pc", 32'(bus.pc), 32'd42);
        check("start_in_run_running", 32'(bus.running), 32'd1);

        // stall at pc 20 with halt and a taken jump presented
        do_jump(4'd0, 1'b1);
        do_jump(4'd1, 1'b1);
        do_inc(2);
        check("pc_20", 32'(bus.pc), 32'd20);
        saved_cnt = m_cnt;
        for (int i = 0; i < 3; i++) begin
            bus.stall        = 1'b1;
            bus.halt         = 1'b1;
            bus.branch_en    = 1'b1;
            bus.branch_taken = 1'b1;
            bus.target_idx   = 4'd2;
            bus.start        = 1'b1;
            step();
            check("stall_pc", 32'(bus.pc), 32'd20);
            check("stall_running", 32'(bus.running), 32'd1);
            check("stall_cnt", 32'(bus.cycle_cnt), 32'(saved_cnt));
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        step();
        idle_inputs();
        check("halt_pc", 32'(bus.pc), 32'd20);
        check("halt_done", 32'(bus.done), 32'd1);
        check("halt_running", 32'(bus.running), 32'd0);
        check("halt_cnt", 32'(bus.cycle_cnt), 32'(saved_cnt) + 32'd1);

        // DONE holds, stall ignored on restart
        bus.stall = 1'b1;
        step();
        step();
        check("done_hold", 32'(bus.done), 32'd1);
        bus.start    = 1'b1;
        bus.prog_sel = 2'd3;
        step();
        idle_inputs();
        check("restart_pc", 32'(bus.pc), 32'd300);
        check("restart_cnt", 32'(bus.cycle_cnt), 32'd0);
        check("restart_done", 32'(bus.done), 32'd0);
        check("restart_running", 32'(bus.running), 32'd1);

        // PC wrap and wide table entry truncation
        do_jump(4'd15, 1'b1);
        do_inc(2);
        check("pc_4095", 32'(bus.pc), 32'd4095);
        do_inc(1);
        check("wrap_pc", 32'(bus.pc), 32'd0);
        check("wrap_running", 32'(bus.running), 32'd1);
        do_jump(4'd14, 1'b1);
        check("trunc_jump", 32'(bus.pc), 32'd2748);
        bus.halt = 1'b1;
        step();
        idle_inputs();

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            reset_n          = ($urandom_range(0, 49) != 0);
            bus.start        = ($urandom_range(0, 7) == 0);
            bus.prog_sel     = 2'($urandom_range(0, 3));
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.branch_en    = $urandom_range(0, 1) == 1;
            bus.branch_taken = $urandom_range(0, 1) == 1;
            bus.target_idx   = 4'($urandom_range(0, 15));
            bus.halt         = ($urandom_range(0, 15) == 0);
            step();
        end
        reset_n = 1'b1;
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 12-bit fetch stage. It owns the PC register, launches a program on a start request, and advances the PC by increment or by an absolute jump resolved through the 16-entry jump-target table. It stops on a decoded halt and reports completion plus a run-cycle count to the top level. It sits between the top-level start/done handshake and instruction memory, fed by decode (`branch_en`, `target_idx`, `halt`) and the ALU (`branch_taken`).

## Interface
- `D`, 12: PC width; instruction memory depth is 2^D.
- `CW`, 16: width of the run-cycle counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request to launch the program selected by `prog_sel`.
- `prog_sel` in 2: index into the entry-address table.
- `stall` in 1: freeze PC, state and counter this cycle.
- `branch_en` in 1: current instruction is a jump.
- `branch_taken` in 1: jump condition true (ALU flag).
- `target_idx` in 4: jump-table index from the instruction.
- `halt` in 1: current instruction is halt.
- `pc` out D: current fetch address.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `cycle_cnt` out CW: number of non-stalled RUN cycles in the last or current program.

## Operation
- States:
  - IDLE: after reset.
  - RUN.
  - DONE.
- IDLE or DONE, `start`=1:
  - `pc` <= ENTRY[`prog_sel`]; `cycle_cnt` <= 0; next state RUN.
  - `stall` is ignored in IDLE and DONE.
- RUN, `stall`=1: all registers hold; `start`, `halt` and branch inputs are ignored.
- RUN, `stall`=0. Priority is halt > taken jump > increment:
  - `halt`=1: next state DONE; `pc` holds; `cycle_cnt` increments.
  - `branch_en`=1 and `branch_taken`=1: `pc` <= JUMP_TABLE[`target_idx`] (zero-extended or truncated to D); `cycle_cnt` increments.
  - otherwise: `pc` <= (`pc`+1) mod 2^D. 2^D−1 wraps to 0; no error is raised.
  - `cycle_cnt` increments in every non-stalled RUN cycle.
- `cycle_cnt` saturates at 2^CW−1.
- `start` during RUN is ignored; a program cannot be restarted until DONE.
- `branch_en`=1 with `branch_taken`=0 increments the PC normally.
- DONE holds `pc` and `cycle_cnt` until the next `start`.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset (`reset_n`=0 at an edge) forces:
  - state IDLE
  - `pc`=0
  - `cycle_cnt`=0
  - `running`=0
  - `done`=0
- Reset takes effect from any state, including mid-RUN, and overrides `start` in the same cycle.
- Start latency: `start` sampled at edge N gives `running`=1 and `pc`=ENTRY after edge N.
- Jump latency: inputs sampled at edge N give the new `pc` visible after edge N. The jump-table lookup is combinational inside the cycle.
- Halt: sampled at edge N; `done`=1 and `running`=0 after edge N. `done` stays high until the edge that accepts `start`.
- `done` and `running` are never both high.

## Structure
- Package `pc_pkg` holds:
  - `state_t` enum {IDLE, RUN, DONE}
  - `ENTRY[0:3]` = 0, 100, 200, 300
  - `JUMP_TABLE[0:15]`; entry 0 = 1, entry 1 = 18, entry 2 = 31, entry 3 = 54, remaining entries fixed by the program image.
- Sub-module `jump_lut`: combinational, 4-bit index in, D-bit target out, contents from `JUMP_TABLE`. It is the only table instance.
- Sequencer body holds:
  - the state register
  - the PC register with next-PC mux
  - the saturating counter

## Test plan
- Reset mid-RUN at `pc`=57 → next cycle `pc`=0, state IDLE, `done`=0, `running`=0, `cycle_cnt`=0.
- `start`, `prog_sel`=1, then 5 free-running cycles → `pc` sequence 100, 101, 102, 103, 104, 105; `cycle_cnt`=5.
- In RUN:
  - `branch_en`=1, `branch_taken`=1, `target_idx`=2 → `pc`=31 next cycle.
  - Same with `branch_taken`=0 at `pc`=40 → `pc`=41.
- `stall` held 3 cycles at `pc`=20 with `halt`=1 and a taken jump presented → `pc` stays 20, state RUN, `cycle_cnt` unchanged. Releasing `stall` with `halt`=1 → DONE, `pc`=20, `done`=1.
- PC forced to reach 4095 in RUN with no jump → next `pc`=0, still RUN.
- `start` during RUN → ignored. After halt, `start` with `prog_sel`=3 → `pc`=300, `cycle_cnt`=0, `done`=0, `running`=1.
